// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches; resolves against EX outcome and trains the predictor.
// Optional macro BRQ_PRED_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  pred_push,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic [1:0]            pred_cnt,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  queue_full,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_target,
    input  logic                  pipe_flush,
    output logic                  branch_ex,
    output logic                  branch_taken_ex,
    output logic [ADDR_WIDTH-1:0] branch_pc_ex,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  resolve_err
`ifdef BRQ_PRED_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_d [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_q [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_d [DEPTH];
    logic [DEPTH-1:0]      tk_q, tk_d;
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  branch_ex_q, branch_ex_d, branch_taken_ex_q, branch_taken_ex_d;
    logic                  mispredict_q, mispredict_d, resolve_err_q, resolve_err_d;
    logic [ADDR_WIDTH-1:0] branch_pc_ex_q, branch_pc_ex_d, redirect_pc_q, redirect_pc_d;
    logic                  push_ok, res_ok, mis, clear, unused_cnt;
    logic [ADDR_WIDTH-1:0] h_pc, h_tgt;
    logic                  h_tk;

    assign unused_cnt = pred_cnt[0];
    assign queue_full = cnt_q == CW'(DEPTH);
    assign push_ok    = pred_push && !queue_full;
    assign res_ok     = resolve_valid && cnt_q != '0;
    assign h_pc       = pc_q[rd_q];
    assign h_tgt      = tgt_q[rd_q];
    assign h_tk       = tk_q[rd_q];
    assign mis        = res_ok && (h_tk != resolve_taken || (h_tk && resolve_taken && h_tgt != resolve_target));
    // younger entries behind a mispredict are wrong-path, so it clears like a flush
    assign clear      = mis || pipe_flush;

    always_comb begin
        pc_d  = pc_q;
        tgt_d = tgt_q;
        tk_d  = tk_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            rd_d  = wr_q;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                pc_d[wr_q]  = pred_pc;
                tgt_d[wr_q] = pred_target;
                tk_d[wr_q]  = pred_cnt[1];
                wr_d        = wr_q + AW'(1);
            end
            rd_d  = rd_q + AW'(res_ok);
            cnt_d = cnt_q + CW'(push_ok) - CW'(res_ok);
        end
        branch_ex_d       = res_ok;
        mispredict_d      = mis;
        branch_taken_ex_d = res_ok ? resolve_taken : branch_taken_ex_q;
        branch_pc_ex_d    = res_ok ? h_pc : branch_pc_ex_q;
        redirect_pc_d     = !res_ok ? redirect_pc_q : resolve_taken ? resolve_target : h_pc + ADDR_WIDTH'(4);
        resolve_err_d     = resolve_err_q || (resolve_valid && cnt_q == '0);
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_q              <= '{default: '0};
            tgt_q             <= '{default: '0};
            tk_q              <= '0;
            wr_q              <= '0;
            rd_q              <= '0;
            cnt_q             <= '0;
            branch_ex_q       <= 1'b0;
            branch_taken_ex_q <= 1'b0;
            branch_pc_ex_q    <= '0;
            mispredict_q      <= 1'b0;
            redirect_pc_q     <= '0;
            resolve_err_q     <= 1'b0;
        end else begin
            pc_q              <= pc_d;
            tgt_q             <= tgt_d;
            tk_q              <= tk_d;
            wr_q              <= wr_d;
            rd_q              <= rd_d;
            cnt_q             <= cnt_d;
            branch_ex_q       <= branch_ex_d;
            branch_taken_ex_q <= branch_taken_ex_d;
            branch_pc_ex_q    <= branch_pc_ex_d;
            mispredict_q      <= mispredict_d;
            redirect_pc_q     <= redirect_pc_d;
            resolve_err_q     <= resolve_err_d;
        end
    end

    assign branch_ex       = branch_ex_q;
    assign branch_taken_ex = branch_taken_ex_q;
    assign branch_pc_ex    = branch_pc_ex_q;
    assign mispredict      = mispredict_q;
    assign redirect_pc     = redirect_pc_q;
    assign resolve_err     = resolve_err_q;

`ifdef BRQ_PRED_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

    // counts land on the same edge that raises branch_ex / mispredict
    always_comb begin
        stat_br_d  = stat_br_q + 32'(branch_ex_d && stat_br_q != '1);
        stat_mis_d = stat_mis_q + 32'(mispredict_d && stat_mis_q != '1);
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif
endmodule
